// File: rtl/mem_sram_responder.sv
// mem_sram_responder: on-chip SRAM endpoint for the memory port of the cache-side
// memory interface controller. It handles one transaction at a time. Read and
// write completion latencies are set by parameters.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   mem_valid/mem_addr   request valid, byte address (low log2(BYTES) bits ignored)
//   mem_wdata/mem_we     write data, 1 = write / 0 = read
//   mem_be               byte enables, used by writes only
//   mem_ready            accept (IDLE) or one-cycle write-completion pulse (WR_DONE)
//   mem_rdata            read data, valid while mem_valid_out = 1, held until the next read
//   mem_valid_out        one-cycle read-data-valid pulse
//   busy                 state != IDLE
//   oor_err/err_clr      sticky out-of-range flag and its clear
//   rd_count/wr_count    completed reads / writes, wrap to 0
//
// Optional feature: define MEM_RESP_STALL_INJECT_EN to add pseudo-random accept
// stalls in IDLE. The stalls come from a 16-bit LFSR.
module mem_sram_responder #(
   parameter int unsigned     ADDR_WIDTH    = 32,
   parameter int unsigned     DATA_WIDTH    = 64,
   parameter int unsigned     DEPTH         = 1024,
   parameter longint unsigned BASE_ADDR     = 64'd0,
   parameter int unsigned     READ_LATENCY  = 4,
   parameter int unsigned     WRITE_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mem_valid,
   input  logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_we,
   input  logic [DATA_WIDTH/8-1:0] mem_be,
   output logic                    mem_ready,
   output logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    mem_valid_out,
   output logic                    busy,
   output logic                    oor_err,
   input  logic                    err_clr,
   output logic [31:0]             rd_count,
   output logic [31:0]             wr_count
);

   localparam int unsigned BYTES = DATA_WIDTH / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] BASE  = 64'(BASE_ADDR);
   localparam logic [63:0] LIMIT = BASE + 64'(DEPTH) * 64'(BYTES);

   // Counter reload values. A write with latency 1 skips WR_WAIT entirely.
   localparam logic [7:0] RD_LOAD = 8'(READ_LATENCY - 1);
   localparam logic [7:0] WR_LOAD = 8'((WRITE_LATENCY > 1) ? (WRITE_LATENCY - 2) : 0);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RD_WAIT = 2'd1;
   localparam logic [1:0] S_WR_WAIT = 2'd2;
   localparam logic [1:0] S_WR_DONE = 2'd3;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [1:0]            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  ready_q, ready_d;
   logic                  vout_q, vout_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  busy_q, busy_d;
   logic                  oor_q, oor_d;
   logic [31:0]           rdc_q, rdc_d;
   logic [31:0]           wrc_q, wrc_d;

   logic [63:0]           addr_ext_c;
   logic                  in_range_c;
   logic [IDX_W-1:0]      idx_c;
   logic                  accept_c;
   logic                  wr_commit_c;
   logic                  stall_c;

   // Address decode: range check and word index relative to BASE_ADDR.
   assign addr_ext_c = 64'(mem_addr);
   assign in_range_c = (addr_ext_c >= BASE) && (addr_ext_c < LIMIT);
   assign idx_c      = IDX_W'((addr_ext_c - BASE) >> OFF_W);

   // A request is accepted only in IDLE while mem_ready is presented.
   assign accept_c    = (state_q == S_IDLE) && ready_q && mem_valid;
   assign wr_commit_c = rst_n && accept_c && mem_we && in_range_c;

`ifdef MEM_RESP_STALL_INJECT_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16,14,13,11, free-running.
   assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   // mem_ready is registered, so the stall is decided from the value the LFSR holds next cycle.
   assign stall_c = (lfsr_d[1:0] == 2'b00);

   always_ff @(posedge clk) begin : lfsr_reg
      if (!rst_n) lfsr_q <= 16'hACE1;
      else        lfsr_q <= lfsr_d;
   end
`else
   assign stall_c = 1'b0;
`endif

   // Byte-enabled write commit on the accept edge. The array has no reset.
   always_ff @(posedge clk) begin : mem_write
      if (wr_commit_c) begin
         for (int i = 0; i < int'(BYTES); i++) begin
            if (mem_be[i]) mem_q[idx_c][i*8 +: 8] <= mem_wdata[i*8 +: 8];
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin : state_reg
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         ready_q <= 1'b1;
         vout_q  <= 1'b0;
         rdata_q <= '0;
         hold_q  <= '0;
         busy_q  <= 1'b0;
         oor_q   <= 1'b0;
         rdc_q   <= 32'd0;
         wrc_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         vout_q  <= vout_d;
         rdata_q <= rdata_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         oor_q   <= oor_d;
         rdc_q   <= rdc_d;
         wrc_q   <= wrc_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin : next_logic
      state_d = state_q;
      cnt_d   = cnt_q;
      vout_d  = 1'b0;
      rdata_d = rdata_q;
      hold_d  = hold_q;
      rdc_d   = rdc_q;
      wrc_d   = wrc_q;
      oor_d   = oor_q;

      case (state_q)
         S_IDLE: begin
            if (accept_c) begin
               if (mem_we) begin
                  state_d = (WRITE_LATENCY <= 1) ? S_WR_DONE : S_WR_WAIT;
                  cnt_d   = WR_LOAD;
               end else begin
                  state_d = S_RD_WAIT;
                  cnt_d   = RD_LOAD;
                  hold_d  = in_range_c ? mem_q[idx_c] : '0;
               end
            end
         end
         S_RD_WAIT: begin
            if (cnt_q == 8'd0) begin
               state_d = S_IDLE;
               vout_d  = 1'b1;
               rdata_d = hold_q;
               rdc_d   = rdc_q + 32'd1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_WR_WAIT: begin
            if (cnt_q == 8'd0) state_d = S_WR_DONE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         S_WR_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The write count becomes visible together with the completion pulse.
      if ((state_d == S_WR_DONE) && (state_q != S_WR_DONE)) wrc_d = wrc_q + 32'd1;

      // Sticky error flag. If a set and a clear happen together, the set wins.
      if (err_clr)                   oor_d = 1'b0;
      if (accept_c && !in_range_c)   oor_d = 1'b1;

      busy_d  = (state_d != S_IDLE);
      ready_d = ((state_d == S_IDLE) && !stall_c) || (state_d == S_WR_DONE);
   end

   assign mem_ready     = ready_q;
   assign mem_rdata     = rdata_q;
   assign mem_valid_out = vout_q;
   assign busy          = busy_q;
   assign oor_err       = oor_q;
   assign rd_count      = rdc_q;
   assign wr_count      = wrc_q;

endmodule

// File: tb/tb_mem_sram_responder.sv
// Self-checking bench for mem_sram_responder: directed scenarios plus randomized traffic
// checked against a word-level reference model.
module tb_mem_sram_responder;

   localparam int unsigned RL  = 4;
   localparam int unsigned WL  = 2;
   localparam int unsigned RL1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, mem_valid, mem_we, err_clr;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;
   logic        mem_ready, mem_valid_out, busy, oor_err;
   logic [63:0] mem_rdata;
   logic [31:0] rd_count, wr_count;

   logic        b_valid, b_we, b_clr;
   logic [31:0] b_addr;
   logic [63:0] b_wdata;
   logic [7:0]  b_be;
   logic        b_ready, b_vout, b_busy, b_oor;
   logic [63:0] b_rdata;
   logic [31:0] b_rdc, b_wrc;

   mem_sram_responder dut (
      .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .mem_valid_out(mem_valid_out), .busy(busy),
      .oor_err(oor_err), .err_clr(err_clr), .rd_count(rd_count), .wr_count(wr_count)
   );

   mem_sram_responder #(.READ_LATENCY(RL1), .WRITE_LATENCY(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .mem_valid(b_valid), .mem_addr(b_addr),
      .mem_wdata(b_wdata), .mem_we(b_we), .mem_be(b_be), .mem_ready(b_ready),
      .mem_rdata(b_rdata), .mem_valid_out(b_vout), .busy(b_busy),
      .oor_err(b_oor), .err_clr(b_clr), .rd_count(b_rdc), .wr_count(b_wrc)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model state
   logic [63:0] d10;
   int unsigned m_rd, m_wr;
   logic        m_oor;

   // Waits until the DUT is idle, issues one request, and returns the edge index of its
   // completion (0 = accept edge, -1 = no completion within the polling window) together
   // with the read data.
   task automatic do_req(input bit we, input logic [31:0] a, input logic [63:0] wd,
                         input logic [7:0] be, input bit clr,
                         output int n, output logic [63:0] rd, output bit rdy_ok);
      rdy_ok = 1'b0;
      for (int k = 0; k < 20 && !rdy_ok; k++) begin
         @(negedge clk);
         rdy_ok = (mem_ready === 1'b1) && (busy === 1'b0);
      end
      mem_valid = 1'b1; mem_we = we; mem_addr = a; mem_wdata = wd; mem_be = be; err_clr = clr;
      @(posedge clk); #1;
      mem_valid = 1'b0; err_clr = 1'b0;
      n  = -1;
      rd = '0;
      for (int k = 0; k < 300; k++) begin
         if (we ? (mem_ready === 1'b1 && busy === 1'b1) : (mem_valid_out === 1'b1)) begin
            n  = k;
            rd = mem_rdata;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_valid = 1'b0; mem_we = 1'b0; err_clr = 1'b0;
      mem_addr = '0; mem_wdata = '0; mem_be = '0;
      b_valid = 1'b0; b_we = 1'b0; b_clr = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
      repeat (2) @(posedge clk);
      #1;
      n_total++; if (mem_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", mem_ready); else n_pass++;
      n_total++; if (mem_valid_out !== 1'b0) $display("FAIL reset_vout: got %b want 0", mem_valid_out); else n_pass++;
      n_total++; if (mem_rdata !== 64'd0) $display("FAIL reset_rdata: got %h want 0", mem_rdata); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++; if (oor_err !== 1'b0) $display("FAIL reset_oor: got %b want 0", oor_err); else n_pass++;
      n_total++; if (rd_count !== 32'd0 || wr_count !== 32'd0)
         $display("FAIL reset_counts: got rd=%0d wr=%0d want 0 0", rd_count, wr_count); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_total++; if (mem_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", mem_ready); else n_pass++;
      m_rd = 0; m_wr = 0; m_oor = 1'b0;
   endtask

   task automatic test_write_read();
      int n; logic [63:0] rd; bit ok;
      d10 = 64'h1122_3344_5566_7788;
      do_req(1'b1, 32'h10, d10, 8'hFF, 1'b0, n, rd, ok); m_wr++;
      n_total++; if (!ok) $display("FAIL wr_idle: DUT not ready/idle before write"); else n_pass++;
      n_total++; if (n !== int'(WL) - 1) $display("FAIL wr_latency: got edge %0d want %0d", n, int'(WL) - 1); else n_pass++;
      n_total++; if (wr_count !== 32'(m_wr)) $display("FAIL wr_count: got %0d want %0d", wr_count, m_wr); else n_pass++;
      do_req(1'b0, 32'h10, '0, 8'h00, 1'b0, n, rd, ok); m_rd++;
      n_total++; if (!ok) $display("FAIL rd_idle: DUT not ready/idle before read"); else n_pass++;
      n_total++; if (n !== int'(RL)) $display("FAIL rd_latency: got edge %0d want %0d", n, RL); else n_pass++;
      n_total++; if (rd !== d10) $display("FAIL rd_data: got %h want %h", rd, d10); else n_pass++;
      n_total++; if (rd_count !== 32'(m_rd)) $display("FAIL rd_count: got %0d want %0d", rd_count, m_rd); else n_pass++;
      n_total++; if (busy !== 1'b0 || mem_ready !== 1'b1)
         $display("FAIL rd_pulse_idle: got busy=%b ready=%b want 0 1", busy, mem_ready); else n_pass++;
   endtask

   task automatic test_partial_write();
      int n; logic [63:0] rd; bit ok;
      do_req(1'b1, 32'h10, 64'hFFFF_FFFF_AAAA_BBBB, 8'h0F, 1'b0, n, rd, ok); m_wr++;
      d10 = 64'h1122_3344_AAAA_BBBB;
      n_total++; if (n !== int'(WL) - 1) $display("FAIL pw_latency: got %0d want %0d", n, int'(WL) - 1); else n_pass++;
      do_req(1'b0, 32'h10, '0, 8'h00, 1'b0, n, rd, ok); m_rd++;
      n_total++; if (rd !== d10) $display("FAIL pw_data: got %h want %h", rd, d10); else n_pass++;
   endtask

   task automatic test_zero_be();
      int n; logic [63:0] rd; bit ok;
      do_req(1'b1, 32'h10, 64'hDEAD_BEEF_0BAD_F00D, 8'h00, 1'b0, n, rd, ok); m_wr++;
      n_total++; if (n !== int'(WL) - 1) $display("FAIL zbe_latency: got %0d want %0d", n, int'(WL) - 1); else n_pass++;
      n_total++; if (wr_count !== 32'(m_wr)) $display("FAIL zbe_count: got %0d want %0d", wr_count, m_wr); else n_pass++;
      do_req(1'b0, 32'h17, '0, 8'h00, 1'b0, n, rd, ok); m_rd++;
      n_total++; if (rd !== d10) $display("FAIL zbe_data: got %h want %h", rd, d10); else n_pass++;
      n_total++; if (oor_err !== 1'b0) $display("FAIL inrange_oor: got %b want 0", oor_err); else n_pass++;
   endtask

   task automatic test_oor();
      int n; logic [63:0] rd; bit ok;
      do_req(1'b0, 32'h2000, '0, 8'h00, 1'b0, n, rd, ok); m_rd++;
      n_total++; if (n !== int'(RL)) $display("FAIL oor_rd_latency: got %0d want %0d", n, RL); else n_pass++;
      n_total++; if (rd !== 64'd0) $display("FAIL oor_rd_data: got %h want 0", rd); else n_pass++;
      n_total++; if (oor_err !== 1'b1) $display("FAIL oor_set: got %b want 1", oor_err); else n_pass++;
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      n_total++; if (oor_err !== 1'b0) $display("FAIL oor_clear: got %b want 0", oor_err); else n_pass++;
      do_req(1'b1, 32'h2000, 64'h1, 8'hFF, 1'b1, n, rd, ok); m_wr++;
      n_total++; if (n !== int'(WL) - 1) $display("FAIL oor_wr_latency: got %0d want %0d", n, int'(WL) - 1); else n_pass++;
      n_total++; if (oor_err !== 1'b1) $display("FAIL oor_set_wins: got %b want 1", oor_err); else n_pass++;
      n_total++; if (wr_count !== 32'(m_wr)) $display("FAIL oor_wr_count: got %0d want %0d", wr_count, m_wr); else n_pass++;
   endtask

   // mem_valid held high: a new read may start only once the previous one has returned to
   // IDLE, which gives one pulse every RL+1 edges.
   task automatic test_valid_held();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = (mem_ready === 1'b1) && (busy === 1'b0);
      end
      mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h10;
      for (int i = 0; i < 3 * int'(RL + 1); i++) begin
         @(posedge clk); #1;
         n_total++;
         if (mem_valid_out !== ((i % int'(RL + 1)) == int'(RL)) || mem_ready !== ((i % int'(RL + 1)) == int'(RL)))
            $display("FAIL held_pattern[%0d]: got vout=%b ready=%b want %b", i, mem_valid_out, mem_ready,
                     (i % int'(RL + 1)) == int'(RL));
         else n_pass++;
      end
      m_rd += 3;
      n_total++; if (rd_count !== 32'(m_rd)) $display("FAIL held_count: got %0d want %0d", rd_count, m_rd); else n_pass++;
      n_total++; if (mem_rdata !== d10) $display("FAIL held_data: got %h want %h", mem_rdata, d10); else n_pass++;
      @(negedge clk); mem_valid = 1'b0;
   endtask

   // Latency-1 instance: single-cycle write completion, no accept in WR_DONE, reads every 2 cycles.
   task automatic test_b2b_rl1();
      logic [63:0] pat;
      pat = 64'hCAFE_0123_4567_89AB;
      @(negedge clk);
      b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h8; b_wdata = pat; b_be = 8'hFF;
      @(posedge clk); #1;
      n_total++; if (b_ready !== 1'b1 || b_busy !== 1'b1)
         $display("FAIL b_wr_done: got ready=%b busy=%b want 1 1", b_ready, b_busy); else n_pass++;
      n_total++; if (b_wrc !== 32'd1) $display("FAIL b_wr_count: got %0d want 1", b_wrc); else n_pass++;
      @(negedge clk); b_we = 1'b0;
      @(posedge clk); #1;
      n_total++; if (b_busy !== 1'b0 || b_ready !== 1'b1)
         $display("FAIL b_no_accept_wr_done: got busy=%b ready=%b want 0 1", b_busy, b_ready); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         n_total++;
         if (b_vout !== ((i % 2) == 1)) $display("FAIL b_b2b[%0d]: got vout=%b want %b", i, b_vout, (i % 2) == 1);
         else n_pass++;
         if (i % 2 == 1) begin
            n_total++; if (b_rdata !== pat) $display("FAIL b_data[%0d]: got %h want %h", i, b_rdata, pat); else n_pass++;
         end
      end
      @(negedge clk); b_valid = 1'b0;
      n_total++; if (b_rdc !== 32'd5) $display("FAIL b_rd_count: got %0d want 5", b_rdc); else n_pass++;
      n_total++; if (b_oor !== 1'b0) $display("FAIL b_oor: got %b want 0", b_oor); else n_pass++;
   endtask

   task automatic test_reset_abort();
      int n; logic [63:0] rd; bit ok; bit seen;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(negedge clk);
         ok = (mem_ready === 1'b1) && (busy === 1'b0);
      end
      mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h10;
      @(posedge clk); #1; mem_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      seen = (mem_valid_out === 1'b1);
      n_total++; if (busy !== 1'b0 || mem_ready !== 1'b1)
         $display("FAIL abort_idle: got busy=%b ready=%b want 0 1", busy, mem_ready); else n_pass++;
      n_total++; if (rd_count !== 32'd0 || wr_count !== 32'd0 || oor_err !== 1'b0)
         $display("FAIL abort_regs: got rd=%0d wr=%0d oor=%b want 0 0 0", rd_count, wr_count, oor_err); else n_pass++;
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (mem_valid_out === 1'b1) seen = 1'b1;
      end
      n_total++; if (seen) $display("FAIL abort_pulse: got a read pulse want none"); else n_pass++;
      n_total++; if (rd_count !== 32'd0) $display("FAIL abort_count: got %0d want 0", rd_count); else n_pass++;
      m_rd = 0; m_wr = 0; m_oor = 1'b0;
      do_req(1'b0, 32'h10, '0, 8'h00, 1'b0, n, rd, ok); m_rd++;
      n_total++; if (rd !== d10) $display("FAIL abort_data_kept: got %h want %h", rd, d10); else n_pass++;
   endtask

   task automatic test_random();
      logic [63:0] mdl [8];
      logic [31:0] maddr [8];
      int n; logic [63:0] rd; bit ok;
      bit we, oor, clr; int slot; logic [31:0] a; logic [63:0] wd, exp_rd; logic [7:0] be;
      for (int s = 0; s < 8; s++) maddr[s] = (s == 7) ? 32'h1FF8 : 32'(s) * 32'h3F8;
      for (int s = 0; s < 8; s++) begin
         mdl[s] = {$urandom, $urandom};
         do_req(1'b1, maddr[s], mdl[s], 8'hFF, 1'b0, n, rd, ok); m_wr++;
         n_total++; if (!ok || n !== int'(WL) - 1) $display("FAIL rnd_init[%0d]: got ok=%b edge=%0d", s, ok, n); else n_pass++;
      end
      for (int t = 0; t < 40; t++) begin
         we   = 1'($urandom_range(0, 1));
         oor  = ($urandom_range(0, 7) == 0);
         clr  = ($urandom_range(0, 3) == 0);
         slot = int'($urandom_range(0, 7));
         if (oor) a = ($urandom_range(0, 1) == 1) ? (32'h2000 + 32'($urandom_range(0, 4095))) : ($urandom | 32'h8000_0000);
         else     a = maddr[slot] | 32'($urandom_range(0, 7));
         wd = {$urandom, $urandom};
         be = 8'($urandom);
         exp_rd = '0;
         if (we) begin
            if (!oor) for (int b = 0; b < 8; b++) if (be[b]) mdl[slot][b*8 +: 8] = wd[b*8 +: 8];
            m_wr++;
         end else begin
            exp_rd = oor ? 64'd0 : mdl[slot];
            m_rd++;
         end
         m_oor = oor ? 1'b1 : (clr ? 1'b0 : m_oor);
         do_req(we, a, wd, be, clr, n, rd, ok);
         n_total++; if (!ok) $display("FAIL rnd_idle[%0d]: DUT not ready/idle", t); else n_pass++;
         n_total++; if (n !== (we ? int'(WL) - 1 : int'(RL)))
            $display("FAIL rnd_latency[%0d]: got %0d want %0d", t, n, we ? int'(WL) - 1 : int'(RL)); else n_pass++;
         if (!we) begin
            n_total++; if (rd !== exp_rd) $display("FAIL rnd_data[%0d] addr %h: got %h want %h", t, a, rd, exp_rd); else n_pass++;
         end
         n_total++; if (oor_err !== m_oor) $display("FAIL rnd_oor[%0d]: got %b want %b", t, oor_err, m_oor); else n_pass++;
         n_total++; if (rd_count !== 32'(m_rd) || wr_count !== 32'(m_wr))
            $display("FAIL rnd_counts[%0d]: got rd=%0d wr=%0d want %0d %0d", t, rd_count, wr_count, m_rd, m_wr); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_partial_write();
      test_zero_be();
      test_oor();
      test_valid_held();
      test_b2b_rl1();
      test_reset_abort();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
